instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the pipelined ARM (LEGv8) processor. It owns the program counter and drives word addresses into the combinational instruction ROM. It registers the returned 32-bit instruction into the IF/ID pipeline register with a valid bit. Stall, branch-redirect and end-of-program handling are resolved here, so the decode stage only sees a clean valid-qualified instruction stream.

## Interface
- PROG_LEN, 7: number of instruction words in the ROM (1..65535). Addresses ≥ PROG_LEN are never fetched.
- RESET_PC, 16'h0000: PC value loaded on reset. Must be < PROG_LEN.
- clk  input  1: single clock; all state updates on rising edge.
- reset  input  1: synchronous, active-high.
- rom_addr  output  16: word address to the ROM. Combinationally equal to the PC register.
- rom_data  input  32: ROM read data, valid in the same cycle as rom_addr.
- stall  input  1: hazard stall from decode. Hold PC and IF/ID.
- redirect  input  1: taken branch/jump resolved downstream.
- redirect_pc  input  16: absolute word address to fetch next when redirect=1.
- if_id_instr  output  32: registered instruction.
- if_id_pc  output  16: address if_id_instr was fetched from.
- if_id_valid  output  1: IF/ID holds a real instruction (0 = bubble).
- done  output  1: fetch has run past the program end (state DONE).
- fetch_count  output  16: instructions delivered to IF/ID. Saturates at 16'hFFFF.

## Operation
- State machine with two states.
  - RUN: fetching.
  - DONE: PC ≥ PROG_LEN, no fetches.
- Reset (highest priority):
  - pc=RESET_PC, state=RUN.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0, fetch_count=0, done=0.
- Per-cycle priority after reset: redirect > stall > normal advance.
- Normal advance (RUN, no stall, no redirect):
  - IF/ID ← {rom_data, pc, valid=1}.
  - fetch_count += 1 (saturating).
  - pc ← pc+1.
  - If pc+1 ≥ PROG_LEN, state ← DONE.
- Stall (no redirect):
  - pc, IF/ID, fetch_count and state all hold.
  - A stalled valid instruction stays on if_id_* unchanged.
- Redirect (any state, stall ignored):
  - IF/ID ← bubble (if_id_valid=0; if_id_instr and if_id_pc hold their old values). The wrong-path instruction is squashed and fetch_count does not increment.
  - pc ← redirect_pc.
  - state ← RUN if redirect_pc < PROG_LEN, else DONE.
- DONE, no redirect:
  - pc holds.
  - if_id_valid ← 0 unless stall=1. A stall holds the last valid instruction.
  - done=1.
  - rom_addr still equals pc. ROM output is ignored.
- PC arithmetic is 16-bit unsigned. The comparison against PROG_LEN is done in 17 bits, so pc=16'hFFFF never wraps back into RUN.

## Timing
- Fetch latency 1 cycle: the word at pc=A in cycle n appears on if_id_instr in cycle n+1 with if_id_pc=A.
- Throughput: one instruction per cycle while unstalled.
- Redirect penalty: exactly one bubble cycle. The target instruction is valid two edges after redirect is sampled.
- done rises on the edge that moves pc to PROG_LEN. The final instruction (address PROG_LEN-1) is valid in that same cycle.
- All outputs except rom_addr are registered.
- Reset asserted mid-program takes effect at the next edge regardless of stall or redirect.

## Test plan
- Reset then free-run, PROG_LEN=7:
  - Cycles 1..7 give if_id_pc=0..6 with if_id_valid=1.
  - Cycle 1 instr=32'hF84000A1; cycle 2 instr=32'hF84010A2.
  - done=1 from cycle 7; fetch_count=7 and frozen afterwards.
  - if_id_valid=0 from cycle 8.
- Stall 3 cycles while if_id_pc=2:
  - if_id_instr=32'h8B010043 held for 4 total cycles.
  - pc held at 3; fetch_count unchanged during the stall.
  - Resumes with if_id_pc=3.
- Redirect to 1 while pc=4, stall also asserted:
  - Next cycle if_id_valid=0, pc=1.
  - Following cycle if_id_pc=1, instr=32'hF84010A2.
  - fetch_count not incremented for the squashed word.
- Redirect from DONE to 5: state returns to RUN, done=0, addresses 5 and 6 are delivered, then done=1 again.
- Redirect to 16'h0009 (≥ PROG_LEN): done=1 next cycle, if_id_valid=0, no fetches.
- Reset asserted during a stall at pc=3: next cycle pc=0, all outputs at reset values, and fetch resumes from address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, ROM addressing and IF/ID pipeline register
// for the LEGv8 fetch stage. The decode stage sees a stream of instructions
// qualified by a valid bit. Stall, redirect and end-of-program are resolved here.
module instr_fetch_unit #(
  parameter int unsigned PROG_LEN = 7,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        done,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // The end-of-program compare is 17 bits wide, so pc+1 from 16'hFFFF cannot wrap.
  localparam logic [16:0] PROG_END = 17'(PROG_LEN);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [16:0] pc_inc;

  // The delivered-instruction counter sticks at all-ones and does not wrap.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state logic. Priority order is redirect, then stall, then normal advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    count_d = count_q;
    pc_inc  = {1'b0, pc_q} + 17'd1;

    if (redirect) begin
      // Squash the wrong-path word. The instruction and PC fields keep their old values.
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      state_d = ({1'b0, redirect_pc} < PROG_END) ? ST_RUN : ST_DONE;
    end else if (stall) begin
      // Hold everything, including a valid instruction that is sitting in IF/ID.
    end else if (state_q == ST_RUN) begin
      instr_d = rom_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      count_d = sat_inc(count_q);
      pc_d    = pc_inc[15:0];
      if (pc_inc >= PROG_END) begin
        state_d = ST_DONE;
      end
    end else begin
      // Past the program end: no fetch, so IF/ID drains to a bubble.
      valid_d = 1'b0;
    end
  end

  // State and pipeline registers. Reset has priority over stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign done        = (state_q == ST_DONE);
  assign fetch_count = count_q;

endmodule
